fetch_sequencer: RTL and testbench

- Control-side partner of the program counter register (15-bit PC with load, output-enable and increment strobes).
- Drives the PC's load (pc_re), output (pc_we) and increment (pc_inc) strobes and reads its address output.
- Issues instruction reads to program memory and hands each fetched word to the decoder over a valid/ready handshake.
- Handles branch redirects by loading a new target into the PC.

---
 rtl/fetch_sequencer.sv | 93 +++++++++
 tb/tb_fetch_sequencer.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: steps the PC, reads program memory and
// hands each fetched word to the decoder, with branch redirects.
module fetch_sequencer #(
   parameter int AW = 15,
   parameter int DW = 16,
   parameter int CW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          run,
   input  logic [AW-1:0] pc_out,
   output logic [AW-1:0] pc_in,
   output logic          pc_re,
   output logic          pc_we,
   output logic          pc_inc,
   output logic [AW-1:0] mem_addr,
   output logic          mem_rd,
   input  logic          mem_ready,
   input  logic [DW-1:0] mem_data,
   output logic [DW-1:0] instr,
   output logic          instr_valid,
   input  logic          instr_ready,
   input  logic          branch_req,
   input  logic [AW-1:0] branch_target,
   output logic [CW-1:0] fetch_count
);

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      REQ,
      VALID,
      INC,
      LOAD
   } state_t;

   state_t state;
   state_t nxt;
   logic   take_branch;

   // A redirect wins over everything except an in-progress load.
   assign take_branch = branch_req && (state != LOAD);

   always_comb begin
      nxt = state;
      if (take_branch) begin
         nxt = LOAD;
      end else begin
         unique case (state)
            IDLE:    nxt = run ? ADDR : IDLE;
            ADDR:    nxt = REQ;
            REQ:     nxt = mem_ready ? VALID : REQ;
            VALID:   nxt = instr_ready ? INC : VALID;
            INC:     nxt = run ? ADDR : IDLE;
            LOAD:    nxt = ADDR;
            default: nxt = IDLE;
         endcase
      end
   end

   // Strobes are registered from the next state so they align with it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         pc_in       <= '0;
         pc_re       <= 1'b0;
         pc_we       <= 1'b0;
         pc_inc      <= 1'b0;
         mem_addr    <= '0;
         mem_rd      <= 1'b0;
         instr       <= '0;
         instr_valid <= 1'b0;
         fetch_count <= '0;
      end else begin
         state       <= nxt;
         pc_re       <= (nxt == LOAD);
         pc_we       <= (nxt == ADDR);
         pc_inc      <= (nxt == INC);
         mem_rd      <= (nxt == REQ);
         instr_valid <= (nxt == VALID);
         if (take_branch)
            pc_in <= branch_target;
         if (state == ADDR && !branch_req)
            mem_addr <= pc_out;
         if (state == REQ && mem_ready && !branch_req)
            instr <= mem_data;
         // Delivery counts even when a redirect arrives in the same cycle.
         if (state == VALID && instr_ready)
            fetch_count <= fetch_count + CW'(1);
      end
   end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a PC model and a
// zero-latency program memory returning addr+0x1000.
module tb_fetch_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        run;
   logic        mem_ready;
   logic        instr_ready;
   logic        branch_req;
   logic [14:0] branch_target;
   logic [14:0] pc;

   logic [14:0] pc_in, mem_addr;
   logic        pc_re, pc_we, pc_inc, mem_rd, instr_valid;
   logic [15:0] instr, mem_data, fetch_count;

   logic [14:0] w_pc_in, w_mem_addr;
   logic        w_pc_re, w_pc_we, w_pc_inc, w_mem_rd, w_instr_valid;
   logic [15:0] w_instr;
   logic [2:0]  w_fetch_count;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int inc_cnt = 0;
   logic [15:0] dq[$];
   int          dc[$];
   logic [14:0] aq[$];

   always #5 clk = ~clk;

   assign mem_data = {1'b0, mem_addr} + 16'h1000;

   fetch_sequencer dut (
      .clk(clk), .rst_n(rst_n), .run(run), .pc_out(pc),
      .pc_in(pc_in), .pc_re(pc_re), .pc_we(pc_we), .pc_inc(pc_inc),
      .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_ready(mem_ready),
      .mem_data(mem_data), .instr(instr), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .branch_req(branch_req),
      .branch_target(branch_target), .fetch_count(fetch_count)
   );

   // Narrow-counter twin sharing all inputs, to see the counter wrap.
   fetch_sequencer #(.CW(3)) dut_w (
      .clk(clk), .rst_n(rst_n), .run(run), .pc_out(pc),
      .pc_in(w_pc_in), .pc_re(w_pc_re), .pc_we(w_pc_we),
      .pc_inc(w_pc_inc), .mem_addr(w_mem_addr), .mem_rd(w_mem_rd),
      .mem_ready(mem_ready), .mem_data(mem_data), .instr(w_instr),
      .instr_valid(w_instr_valid), .instr_ready(instr_ready),
      .branch_req(branch_req), .branch_target(branch_target),
      .fetch_count(w_fetch_count)
   );

   always @(posedge clk) begin
      if (!rst_n) pc <= '0;
      else if (pc_re) pc <= pc_in;
      else if (pc_inc) pc <= pc + 15'd1;
   end

   always @(posedge clk) begin
      if (rst_n) begin
         if (instr_valid && instr_ready) begin
            dq.push_back(instr);
            dc.push_back(cyc);
         end
         if (pc_inc) inc_cnt = inc_cnt + 1;
         if (mem_rd && mem_ready && !branch_req) aq.push_back(mem_addr);
      end
      cyc = cyc + 1;
   end

   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         checks++;
         if ($countones({pc_re, pc_we, pc_inc}) > 1) begin
            failures++;
            $display("FAIL strobe_onehot got=%b want<=1 hot",
                     {pc_re, pc_we, pc_inc});
         end
      end
   end

   task automatic clr();
      dq.delete();
      dc.delete();
      aq.delete();
      inc_cnt = 0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; run = 1'b1; branch_req = 1'b1;
      branch_target = 15'h55; mem_ready = 1'b1; instr_ready = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({pc_in, pc_re, pc_we, pc_inc, mem_addr, mem_rd, instr,
           instr_valid} !== 51'd0) begin
         failures++;
         $display("FAIL reset_outs got=%h want=0", {pc_in, pc_re, pc_we,
                  pc_inc, mem_addr, mem_rd, instr, instr_valid});
      end
      checks++;
      if (fetch_count !== 16'd0) begin
         failures++;
         $display("FAIL reset_count got=%h want=0", fetch_count);
      end
      rst_n = 1'b1; run = 1'b0; branch_req = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({pc_in, pc_re, pc_we, pc_inc, mem_addr, mem_rd, instr,
           instr_valid, fetch_count} !== 67'd0) begin
         failures++;
         $display("FAIL reset_release got=%h want=0", {pc_in, pc_re,
                  pc_we, pc_inc, mem_addr, mem_rd, instr, instr_valid,
                  fetch_count});
      end
   endtask

   task automatic test_seq();
      int n;
      clr();
      n = cyc;
      for (int k = 0; k < 24; k++) begin
         run = (k < 20); mem_ready = 1'b1; instr_ready = 1'b1;
         @(negedge clk);
         if (k == 0) begin
            checks++;
            if (pc_we !== 1'b1) begin
               failures++;
               $display("FAIL seq_addr_we got=%b want=1", pc_we);
            end
         end
         if (k == 2) begin
            checks++;
            if (instr_valid !== 1'b1 || instr !== 16'h1000) begin
               failures++;
               $display("FAIL seq_latency got=%b/%h want=1/1000",
                        instr_valid, instr);
            end
         end
      end
      checks++;
      if (dq.size() != 5 || aq.size() != 5) begin
         failures++;
         $display("FAIL seq_count got=%0d/%0d want=5/5",
                  dq.size(), aq.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            checks++;
            if (dq[i] !== 16'h1000 + 16'(i) || dc[i] != n + 3 + 4 * i ||
                aq[i] !== 15'(i)) begin
               failures++;
               $display("FAIL seq_item%0d got=%h@%0d a=%h want=%h@%0d a=%h",
                        i, dq[i], dc[i], aq[i], 16'h1000 + 16'(i),
                        n + 3 + 4 * i, 15'(i));
            end
         end
      end
      checks++;
      if (fetch_count !== 16'd5 || inc_cnt != 5 || pc !== 15'd5) begin
         failures++;
         $display("FAIL seq_totals got=fc%0d inc%0d pc%0d want=5/5/5",
                  fetch_count, inc_cnt, pc);
      end
      checks++;
      if (pc_we !== 1'b0 || mem_rd !== 1'b0 || instr_valid !== 1'b0) begin
         failures++;
         $display("FAIL seq_idle got=%b%b%b want=000",
                  pc_we, mem_rd, instr_valid);
      end
   endtask

   task automatic test_wait();
      int n;
      clr();
      n = cyc;
      for (int k = 0; k < 16; k++) begin
         run = (k <= 12);
         mem_ready = !(k == 6 || k == 7);
         instr_ready = !(k >= 9 && k <= 11);
         @(negedge clk);
         if (k == 6 || k == 7) begin
            checks++;
            if (mem_rd !== 1'b1 || mem_addr !== 15'd6) begin
               failures++;
               $display("FAIL wait_hold k%0d got=%b/%h want=1/0006",
                        k, mem_rd, mem_addr);
            end
         end
         if (k >= 9 && k <= 11) begin
            checks++;
            if (instr_valid !== 1'b1 || instr !== 16'h1006) begin
               failures++;
               $display("FAIL bp_hold k%0d got=%b/%h want=1/1006",
                        k, instr_valid, instr);
            end
         end
      end
      checks++;
      if (dq.size() != 2) begin
         failures++;
         $display("FAIL wait_count got=%0d want=2", dq.size());
      end else if (dq[0] !== 16'h1005 || dc[0] != n + 3 ||
                   dq[1] !== 16'h1006 || dc[1] != n + 12) begin
         failures++;
         $display("FAIL wait_timing got=%h@%0d %h@%0d want=1005@%0d 1006@%0d",
                  dq[0], dc[0], dq[1], dc[1], n + 3, n + 12);
      end
      checks++;
      if (fetch_count !== 16'd7 || pc !== 15'd7) begin
         failures++;
         $display("FAIL wait_totals got=fc%0d pc%0d want=7/7",
                  fetch_count, pc);
      end
   endtask

   task automatic test_branch();
      clr();
      for (int k = 0; k < 14; k++) begin
         run = (k <= 10); mem_ready = 1'b1; instr_ready = 1'b1;
         branch_req = (k == 2 || k == 6);
         branch_target = (k == 2) ? 15'h0123 : 15'h0040;
         @(negedge clk);
         if (k == 2) begin
            checks++;
            if (pc_re !== 1'b1 || pc_in !== 15'h0123 || mem_rd !== 1'b0 ||
                instr_valid !== 1'b0) begin
               failures++;
               $display("FAIL br_req got=re%b in%h rd%b v%b want=1/0123/0/0",
                        pc_re, pc_in, mem_rd, instr_valid);
            end
         end
         if (k == 4) begin
            checks++;
            if (mem_rd !== 1'b1 || mem_addr !== 15'h0123) begin
               failures++;
               $display("FAIL br_addr got=%b/%h want=1/0123",
                        mem_rd, mem_addr);
            end
         end
         if (k == 6) begin
            checks++;
            if (pc_re !== 1'b1 || pc_in !== 15'h0040 || pc_inc !== 1'b0 ||
                fetch_count !== 16'd8) begin
               failures++;
               $display("FAIL br_valid got=re%b in%h inc%b fc%0d want=1/0040/0/8",
                        pc_re, pc_in, pc_inc, fetch_count);
            end
            checks++;
            if (w_fetch_count !== 3'd0) begin
               failures++;
               $display("FAIL count_wrap got=%0d want=0", w_fetch_count);
            end
         end
         if (k == 8) begin
            checks++;
            if (mem_addr !== 15'h0040) begin
               failures++;
               $display("FAIL br_addr2 got=%h want=0040", mem_addr);
            end
         end
      end
      branch_req = 1'b0;
      checks++;
      if (dq.size() != 2 || aq.size() != 2) begin
         failures++;
         $display("FAIL br_count got=%0d/%0d want=2/2", dq.size(), aq.size());
      end else if (dq[0] !== 16'h1123 || dq[1] !== 16'h1040 ||
                   aq[0] !== 15'h0123) begin
         failures++;
         $display("FAIL br_data got=%h %h a=%h want=1123 1040 a=0123",
                  dq[0], dq[1], aq[0]);
      end
      checks++;
      if (inc_cnt != 1 || fetch_count !== 16'd9 || pc !== 15'h0041) begin
         failures++;
         $display("FAIL br_totals got=inc%0d fc%0d pc%h want=1/9/0041",
                  inc_cnt, fetch_count, pc);
      end
   endtask

   task automatic test_stop_wrap();
      clr();
      for (int k = 0; k < 8; k++) begin
         run = 1'b0; branch_req = (k == 0); branch_target = 15'h7FFF;
         mem_ready = 1'b1; instr_ready = 1'b1;
         @(negedge clk);
         if (k == 0) begin
            checks++;
            if (pc_re !== 1'b1 || pc_in !== 15'h7FFF) begin
               failures++;
               $display("FAIL idle_branch got=%b/%h want=1/7fff", pc_re, pc_in);
            end
         end
         if (k == 2) begin
            checks++;
            if (mem_rd !== 1'b1 || mem_addr !== 15'h7FFF) begin
               failures++;
               $display("FAIL wrap_addr got=%b/%h want=1/7fff", mem_rd, mem_addr);
            end
         end
         if (k == 3) begin
            checks++;
            if (instr_valid !== 1'b1 || instr !== 16'h8FFF) begin
               failures++;
               $display("FAIL wrap_instr got=%b/%h want=1/8fff",
                        instr_valid, instr);
            end
         end
         if (k == 4) begin
            checks++;
            if (pc_inc !== 1'b1 || instr_valid !== 1'b0 ||
                fetch_count !== 16'd10) begin
               failures++;
               $display("FAIL stop_inc got=inc%b v%b fc%0d want=1/0/10",
                        pc_inc, instr_valid, fetch_count);
            end
         end
         if (k == 5 || k == 7) begin
            checks++;
            if ({pc_re, pc_we, pc_inc, mem_rd, instr_valid} !== 5'd0 ||
                pc !== 15'd0) begin
               failures++;
               $display("FAIL stop_idle k%0d got=%b pc%h want=00000 pc0000",
                        k, {pc_re, pc_we, pc_inc, mem_rd, instr_valid}, pc);
            end
         end
      end
      branch_req = 1'b0;
      checks++;
      if (w_fetch_count !== 3'd2) begin
         failures++;
         $display("FAIL wrap_count got=%0d want=2", w_fetch_count);
      end
   endtask

   task automatic test_reset_mid();
      for (int k = 0; k < 5; k++) begin
         rst_n = !(k == 2); run = (k <= 2); mem_ready = 1'b1;
         instr_ready = 1'b1; branch_req = 1'b0;
         @(negedge clk);
         if (k == 1) begin
            checks++;
            if (mem_rd !== 1'b1) begin
               failures++;
               $display("FAIL mid_req got=%b want=1", mem_rd);
            end
         end
         if (k == 2 || k == 4) begin
            checks++;
            if ({pc_re, pc_we, pc_inc, mem_rd, instr_valid} !== 5'd0 ||
                instr !== 16'd0 || fetch_count !== 16'd0 ||
                mem_addr !== 15'd0) begin
               failures++;
               $display("FAIL mid_reset k%0d got=%b i%h fc%0d a%h want=0",
                        k, {pc_re, pc_we, pc_inc, mem_rd, instr_valid},
                        instr, fetch_count, mem_addr);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_seq();
      test_wait();
      test_branch();
      test_stop_wrap();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
